// File: rtl/wb_result_buffer_pkg.sv
// Shared types and sizing for the in-order writeback result buffer.
// Writeback port order: 0=FLU, 1=load, 2=store, 3=FPU; lower index wins on collisions.
package wb_result_buffer_pkg;

  localparam int XLEN          = 64;
  localparam int NR_ENTRIES    = 8;
  localparam int TRANS_ID_BITS = $clog2(NR_ENTRIES);
  localparam int NR_WB_PORTS   = 4;

  typedef logic [TRANS_ID_BITS-1:0] trans_id_t;
  typedef logic [TRANS_ID_BITS:0]   cnt_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

endpackage

// File: rtl/wb_result_buffer_if.sv
// Issue / writeback / commit bundle of the result buffer; master drives requests,
// slave is the buffer itself.
interface wb_result_buffer_if;
  import wb_result_buffer_pkg::*;

  logic                              flush;
  logic                              alloc_valid;
  logic                              alloc_ready;
  trans_id_t                         alloc_trans_id;
  logic       [NR_WB_PORTS-1:0]      wb_valid;
  trans_id_t  [NR_WB_PORTS-1:0]      wb_trans_id;
  logic       [NR_WB_PORTS-1:0][XLEN-1:0] wb_result;
  exception_t [NR_WB_PORTS-1:0]      wb_exception;
  logic                              commit_valid;
  trans_id_t                         commit_trans_id;
  logic       [XLEN-1:0]             commit_result;
  exception_t                        commit_exception;
  logic                              commit_ack;

  modport master (
    output flush, alloc_valid, wb_valid, wb_trans_id, wb_result, wb_exception, commit_ack,
    input  alloc_ready, alloc_trans_id, commit_valid, commit_trans_id, commit_result,
           commit_exception
  );

  modport slave (
    input  flush, alloc_valid, wb_valid, wb_trans_id, wb_result, wb_exception, commit_ack,
    output alloc_ready, alloc_trans_id, commit_valid, commit_trans_id, commit_result,
           commit_exception
  );

endinterface

// File: rtl/wb_result_buffer.sv
// In-order result buffer: issue allocates IDs, functional units complete them in any
// order, commit drains completed entries strictly in allocation order.
module wb_result_buffer
  import wb_result_buffer_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  wb_result_buffer_if.slave   bus
);

  localparam cnt_t CNT_FULL = cnt_t'(NR_ENTRIES);

  logic [NR_ENTRIES-1:0] busy_q, done_q;
  logic [XLEN-1:0]       result_q    [NR_ENTRIES];
  exception_t            exception_q [NR_ENTRIES];
  trans_id_t             head_q, tail_q;
  cnt_t                  cnt_q;

  logic                   alloc_fire, commit_fire;
  logic [NR_WB_PORTS-1:0] wb_accept, wb_dropped, wb_collide;

  assign bus.alloc_ready      = (cnt_q != CNT_FULL);
  assign bus.alloc_trans_id   = tail_q;
  assign bus.commit_valid     = busy_q[head_q] && done_q[head_q];
  assign bus.commit_trans_id  = head_q;
  assign bus.commit_result    = result_q[head_q];
  assign bus.commit_exception = exception_q[head_q];

  assign alloc_fire  = bus.alloc_valid && bus.alloc_ready;
  assign commit_fire = bus.commit_valid && bus.commit_ack;

  // A port is accepted only for a live, not-yet-completed entry that no lower port targets.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wb_accept  = '0;
    wb_dropped = '0;
    wb_collide = '0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      if (bus.wb_valid[p]) begin
        if (!busy_q[bus.wb_trans_id[p]] || done_q[bus.wb_trans_id[p]]) begin
          wb_dropped[p] = 1'b1;
        end else begin
          wb_accept[p] = 1'b1;
          for (int q = 0; q < p; q++) begin
            if (bus.wb_valid[q] && (bus.wb_trans_id[q] == bus.wb_trans_id[p])) begin
              wb_accept[p]  = 1'b0;
              wb_collide[p] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      done_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      // NOTE: payload storage is reset too, so commit outputs read as zero straight out of reset.
      for (int i = 0; i < NR_ENTRIES; i++) begin
        result_q[i]    <= '0;
        exception_q[i] <= '0;
      end
    end else if (bus.flush) begin
      busy_q <= '0;
      done_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every read below sees the pre-edge value.
      if (alloc_fire) begin
        busy_q[tail_q]            <= 1'b1;
        done_q[tail_q]            <= 1'b0;
        exception_q[tail_q].valid <= 1'b0;
        tail_q                    <= tail_q + trans_id_t'(1);
      end
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_accept[p]) begin
          result_q[bus.wb_trans_id[p]]    <= bus.wb_result[p];
          exception_q[bus.wb_trans_id[p]] <= bus.wb_exception[p];
          done_q[bus.wb_trans_id[p]]      <= 1'b1;
        end
      end
      if (commit_fire) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + trans_id_t'(1);
      end
      cnt_q <= cnt_q + cnt_t'(alloc_fire) - cnt_t'(commit_fire);
    end
  end

  // Protocol warnings: the hardware tolerates these, but they point at an upstream bug.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !bus.flush) begin
      assert (wb_dropped == '0)
        else $warning("wb_result_buffer: writeback to idle or completed entry dropped");
      assert (wb_collide == '0)
        else $warning("wb_result_buffer: several ports wrote one entry, lowest port kept");
    end
  end

endmodule

// File: tb/tb_wb_result_buffer.sv
// Directed self-checking bench for wb_result_buffer: ordering, full/wrap, port
// priority, exception passthrough and flush.
module tb_wb_result_buffer;
  import wb_result_buffer_pkg::*;

  logic clk_i;
  logic rst_ni;
  int   n_total;
  int   n_bad;

  wb_result_buffer_if bus ();

  wb_result_buffer dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.flush        = 1'b0;
    bus.alloc_valid  = 1'b0;
    bus.wb_valid     = '0;
    bus.wb_trans_id  = '0;
    bus.wb_result    = '0;
    bus.wb_exception = '0;
    bus.commit_ack   = 1'b0;
  endtask

  task automatic set_wb(input int p, input trans_id_t id, input logic [XLEN-1:0] res,
                        input exception_t ex);
    bus.wb_valid[p]     = 1'b1;
    bus.wb_trans_id[p]  = id;
    bus.wb_result[p]    = res;
    bus.wb_exception[p] = ex;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    #1;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.alloc_valid = 1'b1;
      tick();
    end
    bus.alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++; if (bus.alloc_ready !== 1'b1) begin n_bad++; $display("FAIL reset_alloc_ready: got %0b want 1", bus.alloc_ready); end
    n_total++; if (bus.alloc_trans_id !== 3'd0) begin n_bad++; $display("FAIL reset_alloc_id: got %0d want 0", bus.alloc_trans_id); end
    n_total++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL reset_commit_valid: got %0b want 0", bus.commit_valid); end
    n_total++; if (bus.commit_trans_id !== 3'd0) begin n_bad++; $display("FAIL reset_commit_id: got %0d want 0", bus.commit_trans_id); end
    n_total++; if (bus.commit_result !== 64'd0) begin n_bad++; $display("FAIL reset_commit_result: got %h want 0", bus.commit_result); end
    n_total++; if (bus.commit_exception !== '0) begin n_bad++; $display("FAIL reset_commit_exception: got %h want 0", bus.commit_exception); end
  endtask

  task automatic test_alloc();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.alloc_valid = 1'b1;
      #1;
      n_total++; if (bus.alloc_trans_id !== trans_id_t'(i)) begin n_bad++; $display("FAIL alloc_id: got %0d want %0d", bus.alloc_trans_id, i); end
      n_total++; if (bus.alloc_ready !== 1'b1) begin n_bad++; $display("FAIL alloc_ready: got %0b want 1", bus.alloc_ready); end
      n_total++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL alloc_commit_valid: got %0b want 0", bus.commit_valid); end
      tick();
    end
    idle();
    #1;
    n_total++; if (bus.alloc_trans_id !== 3'd3) begin n_bad++; $display("FAIL alloc_next_id: got %0d want 3", bus.alloc_trans_id); end
    n_total++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL alloc_no_wb_valid: got %0b want 0", bus.commit_valid); end
  endtask

  task automatic test_min_latency();
    do_reset();
    alloc_n(1);
    set_wb(0, 3'd0, 64'h5A, '0);
    #1;
    n_total++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL lat_wb_cycle_valid: got %0b want 0", bus.commit_valid); end
    tick();
    idle();
    #1;
    n_total++; if (bus.commit_valid !== 1'b1) begin n_bad++; $display("FAIL lat_next_cycle_valid: got %0b want 1", bus.commit_valid); end
    n_total++; if (bus.commit_result !== 64'h5A) begin n_bad++; $display("FAIL lat_result: got %h want 5a", bus.commit_result); end
  endtask

  task automatic test_out_of_order();
    logic [XLEN-1:0] exp_res [3];
    exp_res[0] = 64'hA; exp_res[1] = 64'hB; exp_res[2] = 64'hC;
    do_reset();
    alloc_n(3);
    set_wb(3, 3'd2, 64'hC, '0);
    #1;
    n_total++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL ooo_valid_c0: got %0b want 0", bus.commit_valid); end
    tick();
    idle();
    set_wb(1, 3'd1, 64'hB, '0);
    #1;
    n_total++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL ooo_valid_c1: got %0b want 0", bus.commit_valid); end
    tick();
    idle();
    set_wb(0, 3'd0, 64'hA, '0);
    #1;
    n_total++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL ooo_valid_c2: got %0b want 0", bus.commit_valid); end
    tick();
    idle();
    bus.commit_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (bus.commit_valid !== 1'b1) begin n_bad++; $display("FAIL ooo_commit_valid: got %0b want 1 at %0d", bus.commit_valid, i); end
      n_total++; if (bus.commit_trans_id !== trans_id_t'(i)) begin n_bad++; $display("FAIL ooo_commit_id: got %0d want %0d", bus.commit_trans_id, i); end
      n_total++; if (bus.commit_result !== exp_res[i]) begin n_bad++; $display("FAIL ooo_commit_result: got %h want %h", bus.commit_result, exp_res[i]); end
      tick();
    end
    idle();
    #1;
    n_total++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL ooo_drained: got %0b want 0", bus.commit_valid); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < NR_ENTRIES; i++) begin
      bus.alloc_valid = 1'b1;
      #1;
      n_total++; if (bus.alloc_trans_id !== trans_id_t'(i)) begin n_bad++; $display("FAIL full_alloc_id: got %0d want %0d", bus.alloc_trans_id, i); end
      tick();
    end
    #1;
    n_total++; if (bus.alloc_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %0b want 0", bus.alloc_ready); end
    tick();
    set_wb(0, 3'd0, 64'h55, '0);
    #1;
    n_total++; if (bus.alloc_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_held: got %0b want 0", bus.alloc_ready); end
    tick();
    bus.wb_valid   = '0;
    bus.commit_ack = 1'b1;
    #1;
    n_total++; if (bus.commit_valid !== 1'b1) begin n_bad++; $display("FAIL full_commit_valid: got %0b want 1", bus.commit_valid); end
    n_total++; if (bus.alloc_ready !== 1'b0) begin n_bad++; $display("FAIL full_no_bypass: got %0b want 0", bus.alloc_ready); end
    tick();
    bus.commit_ack = 1'b0;
    #1;
    n_total++; if (bus.alloc_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_ready: got %0b want 1", bus.alloc_ready); end
    n_total++; if (bus.alloc_trans_id !== 3'd0) begin n_bad++; $display("FAIL wrap_id: got %0d want 0", bus.alloc_trans_id); end
    n_total++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_head1_valid: got %0b want 0", bus.commit_valid); end
    tick();
    idle();
    #1;
    n_total++; if (bus.alloc_ready !== 1'b0) begin n_bad++; $display("FAIL wrap_full_again: got %0b want 0", bus.alloc_ready); end
    n_total++; if (bus.alloc_trans_id !== 3'd1) begin n_bad++; $display("FAIL wrap_tail: got %0d want 1", bus.alloc_trans_id); end
  endtask

  task automatic test_collision();
    logic [XLEN-1:0] exp_res [5];
    exp_res[0] = 64'hA0; exp_res[1] = 64'hA1; exp_res[2] = 64'hA2; exp_res[3] = 64'hA3;
    exp_res[4] = 64'h11;
    do_reset();
    alloc_n(5);
    set_wb(0, 3'd4, 64'h11, '0);
    set_wb(2, 3'd4, 64'h22, '0);
    tick();
    idle();
    set_wb(1, 3'd4, 64'h33, '0);
    tick();
    idle();
    for (int p = 0; p < NR_WB_PORTS; p++) set_wb(p, trans_id_t'(p), exp_res[p], '0);
    tick();
    idle();
    bus.commit_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++; if (bus.commit_valid !== 1'b1) begin n_bad++; $display("FAIL coll_commit_valid: got %0b want 1 at %0d", bus.commit_valid, i); end
      n_total++; if (bus.commit_result !== exp_res[i]) begin n_bad++; $display("FAIL coll_commit_result: id %0d got %h want %h", i, bus.commit_result, exp_res[i]); end
      tick();
    end
    idle();
  endtask

  task automatic test_exception();
    exception_t ex;
    ex = '{cause: 64'd5, tval: 64'h8000_0000, valid: 1'b1};
    do_reset();
    alloc_n(1);
    set_wb(1, 3'd0, 64'h1234, ex);
    tick();
    idle();
    #1;
    n_total++; if (bus.commit_valid !== 1'b1) begin n_bad++; $display("FAIL exc_commit_valid: got %0b want 1", bus.commit_valid); end
    n_total++; if (bus.commit_exception.valid !== 1'b1) begin n_bad++; $display("FAIL exc_valid: got %0b want 1", bus.commit_exception.valid); end
    n_total++; if (bus.commit_exception.cause !== 64'd5) begin n_bad++; $display("FAIL exc_cause: got %0d want 5", bus.commit_exception.cause); end
    n_total++; if (bus.commit_exception.tval !== 64'h8000_0000) begin n_bad++; $display("FAIL exc_tval: got %h want 80000000", bus.commit_exception.tval); end
    n_total++; if (bus.commit_result !== 64'h1234) begin n_bad++; $display("FAIL exc_result: got %h want 1234", bus.commit_result); end
    bus.commit_ack = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_flush();
    int accepted;
    do_reset();
    alloc_n(5);
    set_wb(0, 3'd0, 64'h1, '0);
    set_wb(1, 3'd1, 64'h2, '0);
    tick();
    idle();
    bus.flush       = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.commit_ack  = 1'b1;
    set_wb(2, 3'd2, 64'h77, '0);
    #1;
    n_total++; if (bus.commit_valid !== 1'b1) begin n_bad++; $display("FAIL flush_pre_valid: got %0b want 1", bus.commit_valid); end
    n_total++; if (bus.alloc_trans_id !== 3'd5) begin n_bad++; $display("FAIL flush_pre_id: got %0d want 5", bus.alloc_trans_id); end
    tick();
    idle();
    #1;
    n_total++; if (bus.alloc_trans_id !== 3'd0) begin n_bad++; $display("FAIL flush_id: got %0d want 0", bus.alloc_trans_id); end
    n_total++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %0b want 0", bus.commit_valid); end
    n_total++; if (bus.commit_trans_id !== 3'd0) begin n_bad++; $display("FAIL flush_head: got %0d want 0", bus.commit_trans_id); end
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      bus.alloc_valid = 1'b1;
      #1;
      if (bus.alloc_ready === 1'b1) accepted++;
      tick();
    end
    idle();
    #1;
    n_total++; if (accepted !== 8) begin n_bad++; $display("FAIL flush_capacity: got %0d want 8", accepted); end
    n_total++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL flush_stale_done: got %0b want 0", bus.commit_valid); end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_ni  = 1'b0;
    idle();
    test_reset();
    test_alloc();
    test_min_latency();
    test_out_of_order();
    test_full_wrap();
    test_collision();
    test_exception();
    test_flush();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
